button_event_filter: RTL and testbench

BUTTON_EVENT_FILTER -- requirements
Module: button_event_filter

---
 rtl/button_event_pkg.sv | 27 ++
 rtl/debounce_filter.sv | 53 +++++
 rtl/button_event_filter.sv | 112 +++++++++++
 tb/tb_button_event_filter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared button IDs, combo FSM encoding and a small priority helper for the button event filter.
package button_event_pkg;

  localparam logic [1:0] BTN_ID_1 = 2'd0;
  localparam logic [1:0] BTN_ID_2 = 2'd1;
  localparam logic [1:0] BTN_ID_3 = 2'd2;
  localparam logic [1:0] BTN_ID_4 = 2'd3;

  localparam int unsigned NUM_BUTTONS = 4;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ACTIVE = 2'd1,
    C_DRAIN  = 2'd2
  } combo_state_e;

  // Index of the lowest set bit; BTN_ID_1 when the mask is empty.
  function automatic logic [1:0] lowest_idx(input logic [NUM_BUTTONS-1:0] mask);
    logic [1:0] idx;
    idx = BTN_ID_1;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch: 2-flop synchroniser, mismatch counter and debounced stable level.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_LIMIT - 1);

  logic            sync_meta_q;
  logic            sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            toggle;

  always_comb begin
    toggle  = 1'b0;
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q == CntLast) begin
        toggle  = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_meta_q <= raw;
      sync_q      <= sync_meta_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  // Combinational so the pending mask captures the release on the same edge the level falls.
  assign fall  = toggle & level_q;

endmodule

// File: rtl/button_event_filter.sv
// Four debounced switches, release-event queue (lowest index first) and optional
// Switch_1+Switch_2 combo detector enabled by defining BUTTON_COMBO_EN.
module button_event_filter
  import button_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Switch_Level,
  output logic       o_Button_DV,
  output logic [1:0] o_Button_ID,
  output logic       o_Combo
);

  logic [NUM_BUTTONS-1:0] raw;
  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] fall;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_db
    debounce_filter #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_debounce_filter (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .raw   (raw[g]),
      .level (level[g]),
      .fall  (fall[g])
    );
  end

  logic [NUM_BUTTONS-1:0] keep_mask;
  logic [NUM_BUTTONS-1:0] clr_mask;

`ifdef BUTTON_COMBO_EN
  combo_state_e combo_state_q, combo_state_d;

  always_comb begin
    combo_state_d = combo_state_q;
    unique case (combo_state_q)
      C_IDLE:   if (level[0] && level[1])   combo_state_d = C_ACTIVE;
      C_ACTIVE: if (!level[0] || !level[1]) combo_state_d = C_DRAIN;
      C_DRAIN:  if (!level[0] && !level[1]) combo_state_d = C_IDLE;
      default:  combo_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      combo_state_q <= C_IDLE;
    end else begin
      combo_state_q <= combo_state_d;
    end
  end

  // Switch 1/2 releases belong to the combo gesture, so they are swallowed until both are up.
  always_comb begin
    keep_mask = (combo_state_q != C_IDLE) ? 4'b1100 : 4'b1111;
    clr_mask  = ((combo_state_q == C_IDLE) && (combo_state_d == C_ACTIVE)) ? 4'b0011 : 4'b0000;
  end

  assign o_Combo = (combo_state_q == C_ACTIVE);
`else
  assign keep_mask = 4'b1111;
  assign clr_mask  = 4'b0000;
  assign o_Combo   = 1'b0;
`endif

  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic [NUM_BUTTONS-1:0] avail;
  logic [NUM_BUTTONS-1:0] grant;
  logic [1:0]             grant_id;
  logic                   dv_q, dv_d;
  logic [1:0]             id_q, id_d;

  always_comb begin
    avail     = pending_q & ~clr_mask;
    grant_id  = lowest_idx(avail);
    grant     = '0;
    dv_d      = |avail;
    id_d      = BTN_ID_1;
    if (dv_d) begin
      grant[grant_id] = 1'b1;
      id_d            = grant_id;
    end
    // A fresh release on a bit being granted this cycle re-arms it rather than being lost.
    pending_d = (avail & ~grant) | (fall & keep_mask);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pending_q <= '0;
      dv_q      <= 1'b0;
      id_q      <= BTN_ID_1;
    end else begin
      pending_q <= pending_d;
      dv_q      <= dv_d;
      id_q      <= id_d;
    end
  end

  assign o_Switch_Level = level;
  assign o_Button_DV    = dv_q;
  assign o_Button_ID    = id_q;

endmodule

// File: tb/tb_button_event_filter.sv
// Scoreboard bench for button_event_filter at DEBOUNCE_LIMIT=4; honours BUTTON_COMBO_EN.
module tb_button_event_filter;
  import button_event_pkg::*;

  localparam int unsigned Limit = 4;
  localparam int Lat = Limit + 2;  // drive cycle to stable-level change

`ifdef BUTTON_COMBO_EN
  localparam int ComboEn = 1;
`else
  localparam int ComboEn = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic [3:0] level;
  logic       dv;
  logic [1:0] id;
  logic       combo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  button_event_filter #(
    .DEBOUNCE_LIMIT (Limit)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Switch_1     (sw1),
    .i_Switch_2     (sw2),
    .i_Switch_3     (sw3),
    .i_Switch_4     (sw4),
    .o_Switch_Level (level),
    .o_Button_DV    (dv),
    .o_Button_ID    (id),
    .o_Combo        (combo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(input logic [3:0] v);
    {sw4, sw3, sw2, sw1} = v;
  endtask

  task automatic push_exp(input int eid, input int ecyc);
    exp_t e;
    e.id  = eid;
    e.cyc = ecyc;
    exp_q.push_back(e);
  endtask

  // Every DV pulse must match the head of the scoreboard in both ID and cycle.
  always @(negedge clk) begin
    if (dv) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_dv", int'(id), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("dv_id", int'(id), e.id);
        check_eq("dv_cycle", cyc, e.cyc);
      end
    end else begin
      check_eq("id_idle_zero", int'(id), 0);
    end
  end

  initial begin
    int c;

    step(3);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_dv", int'(dv), 0);
    check_eq("rst_id", int'(id), 0);
    check_eq("rst_combo", int'(combo), 0);
    rst = 1'b0;
    step(2);

    // Switch_3 press 10 clocks then release.
    set_sw(4'b0100);
    step(Lat - 1);
    check_eq("sw3_level_early", int'(level[2]), 0);
    step(1);
    check_eq("sw3_level_rise", int'(level[2]), 1);
    step(10 - Lat);
    set_sw(4'b0000);
    push_exp(int'(BTN_ID_3), cyc + Lat + 1);
    step(Lat);
    check_eq("sw3_level_fall", int'(level[2]), 0);
    step(6);
    check_eq("sw3_drained", exp_q.size(), 0);

    // Short glitch on Switch_1.
    set_sw(4'b0001);
    step(3);
    set_sw(4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_eq("glitch_level", int'(level), 0);
    end

    // Switches 2 and 4 released together.
    set_sw(4'b1010);
    step(10);
    check_eq("sw24_level", int'(level), 4'b1010);
    set_sw(4'b0000);
    push_exp(int'(BTN_ID_2), cyc + Lat + 1);
    push_exp(int'(BTN_ID_4), cyc + Lat + 2);
    step(12);
    check_eq("sw24_drained", exp_q.size(), 0);

    // Combo: Switch_1 and Switch_2 held together.
    set_sw(4'b0011);
    step(Lat + 2);
    check_eq("combo_levels", int'(level), 4'b0011);
    check_eq("combo_active", int'(combo), ComboEn);
    step(6);
    check_eq("combo_hold", int'(combo), ComboEn);
    set_sw(4'b0000);
    if (ComboEn == 0) begin
      push_exp(int'(BTN_ID_1), cyc + Lat + 1);
      push_exp(int'(BTN_ID_2), cyc + Lat + 2);
    end
    step(12);
    check_eq("combo_off", int'(combo), 0);
`ifdef BUTTON_COMBO_EN
    check_eq("combo_idle", int'(dut.combo_state_q), int'(C_IDLE));
`endif
    check_eq("combo_drained", exp_q.size(), 0);

    // Switch_1 alone afterwards still produces its event.
    set_sw(4'b0001);
    step(10);
    set_sw(4'b0000);
    push_exp(int'(BTN_ID_1), cyc + Lat + 1);
    step(12);
    check_eq("sw1_after_combo_drained", exp_q.size(), 0);

    // Reset mid-debounce: held switch is debounced afresh.
    set_sw(4'b0001);
    c = cyc;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    check_eq("mid_rst_level_low", int'(level[0]), 0);
    step(1);
    check_eq("mid_rst_level_rise", int'(level[0]), 1);
    check_eq("mid_rst_rise_cycle", cyc - c, 10);
    set_sw(4'b0000);
    push_exp(int'(BTN_ID_1), cyc + Lat + 1);
    step(12);
    check_eq("mid_rst_drained", exp_q.size(), 0);

    // Reset with Switch_4 pending: the event is discarded.
    set_sw(4'b1000);
    step(10);
    set_sw(4'b0000);
    step(Lat);
    check_eq("pend_level_fell", int'(level[3]), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("pend_rst_level", int'(level), 0);
    check_eq("pend_rst_dv", int'(dv), 0);
    check_eq("pend_rst_id", int'(id), 0);
    check_eq("pend_rst_combo", int'(combo), 0);
    step(12);
    check_eq("pend_rst_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
